div_unit: RTL and testbench

Multi-cycle 32-bit integer divider: the responder end of the execute stage's divider handshake. It accepts divisor and dividend on two independent valid/ready channels and computes quotient and remainder with a radix-2 restoring iteration. It returns both as one 64-bit result word with a single-cycle done pulse. Two instances sit beside the execute stage: one signed (div.w/mod.w), one unsigned (div.wu/mod.wu).

---
 rtl/div_pkg.sv | 30 +++
 rtl/div_step.sv | 33 +++
 rtl/div_unit.sv | 172 +++++++++++++++++
 tb/tb_div_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle integer divider: the state encoding,
// operand width, iteration count, divide-by-zero quotient, and a helper that
// takes an operand's magnitude.
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;

    // Counter value on the edge that performs the final restoring iteration
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_ITERS - 1);

    // Quotient returned for a zero divisor (all ones)
    localparam logic [DIV_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Magnitude of a two's-complement value when en is set, else pass-through.
    // -2^31 maps to 32'h8000_0000, which is the correct unsigned magnitude.
    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v,
                                                 input logic             en);
        return (en && v[DIV_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// rq_in packs {partial remainder, quotient/dividend shift register}; the
// shift brings the next dividend bit into the remainder, a trial subtract
// decides the quotient bit shifted in at the LSB.
module div_step
    import div_pkg::*;
(
    input  logic [2*DIV_W-1:0] rq_in,
    input  logic [DIV_W-1:0]   dmag,
    output logic [2*DIV_W-1:0] rq_out
);

    // 33-bit shifted remainder and 34-bit trial difference (top bit = borrow)
    logic [DIV_W:0]   part;
    logic [DIV_W+1:0] diff;
    logic             unused_diff_bit;

    // Remainder stays below the divisor, so a non-borrowing difference
    // always fits back into DIV_W bits.
    assign unused_diff_bit = diff[DIV_W];

    // Shift, trial-subtract, and keep or restore
    always_comb begin
        part = {rq_in[2*DIV_W-1:DIV_W], rq_in[DIV_W-1]};
        diff = {1'b0, part} - {2'b00, dmag};
        if (!diff[DIV_W+1]) begin
            rq_out = {diff[DIV_W-1:0], rq_in[DIV_W-2:0], 1'b1};
        end else begin
            rq_out = {part[DIV_W-1:0], rq_in[DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit integer divider (signed or unsigned via SIGNED).
// Takes divisor and dividend on independent valid/ready channels, iterates a
// restoring divider for 32 cycles, fixes signs, and returns {quotient,
// remainder} with a one-cycle dout_valid pulse.
//
// Handshake: a channel transfers on any rising edge where its valid and
// ready are both high. Ready is a decode of registered state only (IDLE and
// that channel's operand not yet held); valid never feeds ready. The result
// side has no ready: dout_valid is a one-cycle pulse and dout_data holds
// until the next result is written.
//
// Optional feature: define DIV_UNIT_ZERO_FAST_EN to short-cut a zero divisor
// from IDLE straight to DONE (result in the cycle after the last transfer).
// Without it, zero divisors run the full iteration with the same result.
module div_unit
    import div_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIV_W-1:0]   divisor_data,
    input  logic               divisor_valid,
    output logic               divisor_ready,
    input  logic [DIV_W-1:0]   dividend_data,
    input  logic               dividend_valid,
    output logic               dividend_ready,
    output logic               dout_valid,
    output logic [2*DIV_W-1:0] dout_data,
    output logic [1:0]         dbg_state
);

    div_state_e         state_q, state_d;
    logic               divisor_held_q, divisor_held_d;
    logic               dividend_held_q, dividend_held_d;
    logic [DIV_W-1:0]   divisor_q, divisor_d;
    logic [DIV_W-1:0]   dividend_q, dividend_d;
    logic [2*DIV_W-1:0] rq_q, rq_d;
    logic [DIV_W-1:0]   dmag_q, dmag_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dout_valid_q, dout_valid_d;
    logic [2*DIV_W-1:0] dout_data_q, dout_data_d;

    logic               divisor_take, dividend_take;
    logic [DIV_W-1:0]   dvs_v, dvd_v;
    logic [DIV_W-1:0]   quo_fix, rem_fix;
    logic [2*DIV_W-1:0] step_out;

    div_step u_step (
        .rq_in  (rq_q),
        .dmag   (dmag_q),
        .rq_out (step_out)
    );

    // Readies come from registered state only
    assign divisor_ready  = (state_q == IDLE) && !divisor_held_q;
    assign dividend_ready = (state_q == IDLE) && !dividend_held_q;
    assign divisor_take   = divisor_valid && divisor_ready;
    assign dividend_take  = dividend_valid && dividend_ready;

    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;
    assign dbg_state  = state_q;

    // Next-state logic for the FSM, operand capture, iteration and sign fix
    always_comb begin
        state_d         = state_q;
        divisor_held_d  = divisor_held_q;
        dividend_held_d = dividend_held_q;
        divisor_d       = divisor_q;
        dividend_d      = dividend_q;
        rq_d            = rq_q;
        dmag_d          = dmag_q;
        neg_quo_d       = neg_quo_q;
        neg_rem_d       = neg_rem_q;
        cnt_d           = cnt_q;
        dout_valid_d    = 1'b0;
        dout_data_d     = dout_data_q;

        // Operand values as seen on this edge, including same-edge transfers
        dvs_v = divisor_take  ? divisor_data  : divisor_q;
        dvd_v = dividend_take ? dividend_data : dividend_q;

        quo_fix = neg_quo_q ? -rq_q[DIV_W-1:0]       : rq_q[DIV_W-1:0];
        rem_fix = neg_rem_q ? -rq_q[2*DIV_W-1:DIV_W] : rq_q[2*DIV_W-1:DIV_W];

        case (state_q)
            IDLE: begin
                if (divisor_take) begin
                    divisor_d      = divisor_data;
                    divisor_held_d = 1'b1;
                end
                if (dividend_take) begin
                    dividend_d      = dividend_data;
                    dividend_held_d = 1'b1;
                end
                if ((divisor_held_q || divisor_take) &&
                    (dividend_held_q || dividend_take)) begin
                    rq_d   = {{DIV_W{1'b0}}, abs_val(dvd_v, SIGNED)};
                    dmag_d = abs_val(dvs_v, SIGNED);
                    // A zero divisor keeps the all-ones quotient unnegated
                    neg_quo_d = SIGNED && (dvd_v[DIV_W-1] ^ dvs_v[DIV_W-1]) &&
                                (dvs_v != '0);
                    neg_rem_d = SIGNED && dvd_v[DIV_W-1];
                    cnt_d     = '0;
                    state_d   = CALC;
`ifdef DIV_UNIT_ZERO_FAST_EN
                    if (dvs_v == '0) begin
                        dout_data_d  = {DIV_ZERO_QUO, dvd_v};
                        dout_valid_d = 1'b1;
                        state_d      = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rq_d  = step_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                dout_data_d  = {quo_fix, rem_fix};
                dout_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                divisor_held_d  = 1'b0;
                dividend_held_d = 1'b0;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            divisor_held_q  <= 1'b0;
            dividend_held_q <= 1'b0;
            divisor_q       <= '0;
            dividend_q      <= '0;
            rq_q            <= '0;
            dmag_q          <= '0;
            neg_quo_q       <= 1'b0;
            neg_rem_q       <= 1'b0;
            cnt_q           <= '0;
            dout_valid_q    <= 1'b0;
            dout_data_q     <= '0;
        end else begin
            state_q         <= state_d;
            divisor_held_q  <= divisor_held_d;
            dividend_held_q <= dividend_held_d;
            divisor_q       <= divisor_d;
            dividend_q      <= dividend_d;
            rq_q            <= rq_d;
            dmag_q          <= dmag_d;
            neg_quo_q       <= neg_quo_d;
            neg_rem_q       <= neg_rem_d;
            cnt_q           <= cnt_d;
            dout_valid_q    <= dout_valid_d;
            dout_data_q     <= dout_data_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: one signed and one unsigned instance share the operand
// inputs. Table vectors with hand-derived results, a split-arrival case, a
// mid-operation reset, then random operands against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] divisor_data, dividend_data;
    logic        divisor_valid, dividend_valid;

    logic        dvs_rdy_u, dvd_rdy_u, dv_u;
    logic        dvs_rdy_s, dvd_rdy_s, dv_s;
    logic [63:0] dout_u, dout_s;
    logic [1:0]  dbg_u, dbg_s;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] exp_u_q[$];
    logic [63:0] exp_s_q[$];

`ifdef DIV_UNIT_ZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
        logic [63:0] exp_u;
        logic [63:0] exp_s;
    } vec_t;

    vec_t vecs[9];

    // Clock and reset
    always #5 clk = ~clk;

    div_unit #(.SIGNED(1'b0)) u_dut_u (
        .clk(clk), .reset(reset),
        .divisor_data(divisor_data), .divisor_valid(divisor_valid), .divisor_ready(dvs_rdy_u),
        .dividend_data(dividend_data), .dividend_valid(dividend_valid), .dividend_ready(dvd_rdy_u),
        .dout_valid(dv_u), .dout_data(dout_u), .dbg_state(dbg_u)
    );

    div_unit #(.SIGNED(1'b1)) u_dut_s (
        .clk(clk), .reset(reset),
        .divisor_data(divisor_data), .divisor_valid(divisor_valid), .divisor_ready(dvs_rdy_s),
        .dividend_data(dividend_data), .dividend_valid(dividend_valid), .dividend_ready(dvd_rdy_s),
        .dout_valid(dv_s), .dout_data(dout_s), .dbg_state(dbg_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic from the division rules
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        int          sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        qq = q;
        rr = r;
        return {qq, rr};
    endfunction

    // Driver: dividend in cycle 0, divisor in cycle gap; check the result
    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input int gap, input logic [63:0] eu, input logic [63:0] es);
        int          lat;
        int          exp_lat;
        logic [63:0] xu, xs;
        exp_u_q.push_back(eu);
        exp_s_q.push_back(es);
        exp_lat = (FAST_ZERO && b == 32'd0) ? 1 : 34;

        @(posedge clk); #1;
        dividend_data  = a;
        dividend_valid = 1'b1;
        if (gap == 0) begin
            divisor_data  = b;
            divisor_valid = 1'b1;
        end
        for (int c = 1; c <= gap; c++) begin
            @(posedge clk); #1;
            check($sformatf("%s_split_rdy_c%0d", name, c),
                  {60'd0, dvd_rdy_u, dvd_rdy_s, dvs_rdy_u, dvs_rdy_s}, 64'b0011);
            // Held-high valid with fresh data must not be re-taken
            dividend_data = a ^ 32'hA5A5_5A5A;
            if (c == gap) begin
                divisor_data  = b;
                divisor_valid = 1'b1;
            end
        end

        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                dividend_valid = 1'b0;
                divisor_valid  = 1'b0;
                check({name, "_rdy_busy"},
                      {60'd0, dvd_rdy_u, dvd_rdy_s, dvs_rdy_u, dvs_rdy_s}, 64'd0);
            end
            if (dv_u || dv_s) begin
                lat = n;
                check({name, "_valid_pair"}, {62'd0, dv_u, dv_s}, 64'b11);
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));

        xu = exp_u_q.pop_front();
        xs = exp_s_q.pop_front();
        check({name, "_data_u"}, dout_u, xu);
        check({name, "_data_s"}, dout_s, xs);

        // Pulse is one cycle, readies return, data holds
        @(posedge clk); #1;
        check({name, "_after"},
              {58'd0, dv_u, dv_s, dvd_rdy_u, dvd_rdy_s, dvs_rdy_u, dvs_rdy_s}, 64'b001111);
        check({name, "_hold_s"}, dout_s, xs);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;

        vecs[0] = '{"u100_7",    32'd100,         32'd7,           0,
                    {32'd14, 32'd2},                 {32'd14, 32'd2}};
        vecs[1] = '{"m7_2",      32'hFFFF_FFF9,   32'd2,           0,
                    {32'h7FFF_FFFC, 32'd1},          {32'hFFFF_FFFD, 32'hFFFF_FFFF}};
        vecs[2] = '{"min_m1",    32'h8000_0000,   32'hFFFF_FFFF,   0,
                    {32'd0, 32'h8000_0000},          {32'h8000_0000, 32'h0}};
        vecs[3] = '{"div0_pos",  32'd5,           32'd0,           0,
                    {32'hFFFF_FFFF, 32'd5},          {32'hFFFF_FFFF, 32'd5}};
        vecs[4] = '{"div0_neg",  32'hFFFF_FFFB,   32'd0,           0,
                    {32'hFFFF_FFFF, 32'hFFFF_FFFB},  {32'hFFFF_FFFF, 32'hFFFF_FFFB}};
        vecs[5] = '{"m100_m7",   32'hFFFF_FF9C,   32'hFFFF_FFF9,   0,
                    {32'd0, 32'hFFFF_FF9C},          {32'd14, 32'hFFFF_FFFE}};
        vecs[6] = '{"split",     32'd1000,        32'd33,          3,
                    {32'd30, 32'd10},                {32'd30, 32'd10}};
        vecs[7] = '{"p64_m7",    32'd64,          32'hFFFF_FFF9,   0,
                    {32'd0, 32'd64},                 {32'hFFFF_FFF7, 32'd1}};
        vecs[8] = '{"m1_1",      32'hFFFF_FFFF,   32'd1,           1,
                    {32'hFFFF_FFFF, 32'd0},          {32'hFFFF_FFFF, 32'd0}};

        reset          = 1'b1;
        divisor_data   = '0;
        dividend_data  = '0;
        divisor_valid  = 1'b0;
        dividend_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_ctrl",
              {58'd0, dv_u, dv_s, dvd_rdy_u, dvd_rdy_s, dvs_rdy_u, dvs_rdy_s}, 64'b001111);
        check("reset_data_u", dout_u, 64'd0);
        check("reset_data_s", dout_s, 64'd0);

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].gap,
                  vecs[i].exp_u, vecs[i].exp_s);
        end

        // Reset in CALC cycle 10 abandons the result
        @(posedge clk); #1;
        dividend_data  = 32'd100;
        divisor_data   = 32'd7;
        dividend_valid = 1'b1;
        divisor_valid  = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                dividend_valid = 1'b0;
                divisor_valid  = 1'b0;
            end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_rdy",
              {58'd0, dv_u, dv_s, dvd_rdy_u, dvd_rdy_s, dvs_rdy_u, dvs_rdy_s}, 64'b001111);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (dv_u || dv_s) pulses++;
        end
        check("midreset_no_pulse", 64'(pulses), 64'd0);
        do_op("after_reset_9_3", 32'd9, 32'd3, 0, {32'd3, 32'd0}, {32'd3, 32'd0});

        // Random operands against the model
        for (int k = 0; k < 25; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = -($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 200);
            do_op($sformatf("rand%0d", k), ra, rb, $urandom_range(0, 2),
                  ref_div(1'b0, ra, rb), ref_div(1'b1, ra, rb));
        end

        pulse_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
